i2c_reg_bank: RTL and testbench
===============================

// Module: i2c_reg_bank
// PURPOSE
//  Register file that sits directly downstream of the I2C slave and consumes its reg_* strobe interface.
//  Holds ID/version, scratch and control registers, a W1C sticky event/IRQ block, a write counter,
//  and an 8-bit FPGA->MCU mailbox FIFO that the STM32 drains through a pop-on-read data register.
// PARAMETERS
//  DEVICE_ID   8'hA5  value returned at 0x00
//  VERSION     8'h12  value returned at 0x01
//  FIFO_DEPTH  8      mailbox depth; power of two, 2..16
// PORTS
//  clk           in   1  system clock (100 MHz)
//  rst           in   1  synchronous, active-high reset
//  reg_addr      in   8  register address from I2C slave
//  reg_wdata     in   8  write data from I2C slave
//  reg_wr        in   1  single-cycle write strobe
//  reg_rdata     out  8  read data to I2C slave
//  reg_rd        in   1  read/prefetch indication (level or pulse)
//  evt_i         in   7  fabric event pulses, one per IRQ_STAT bit [6:0]
//  fifo_wr_i     in   1  mailbox push strobe from fabric
//  fifo_wdata_i  in   8  mailbox push data
//  fifo_full_o   out  1  mailbox full
//  ctrl_o        out  8  CTRL register contents
//  irq_o         out  1  registered, |(IRQ_STAT & IRQ_MASK)
// BEHAVIOUR
//  Reset: one clock with rst=1. All registers, FIFO pointers, count and WR_COUNT cleared.
//   reg_rdata=0, ctrl_o=0, irq_o=0, fifo_full_o=0.
//  Map (others read 0x00, writes ignored):
//   0x00 DEVICE_ID RO | 0x01 VERSION RO | 0x02 SCRATCH RW | 0x03 CTRL RW (drives ctrl_o)
//   0x04 IRQ_STAT W1C: [6:0] set by evt_i, [7] mailbox overflow | 0x05 IRQ_MASK RW
//   0x06 FIFO_STAT RO {full, empty, 1'b0, count[4:0]} | 0x07 FIFO_DATA RO, head entry, pop on read
//   0x08 WR_COUNT RO: +1 per reg_wr to any address, wraps 0xFF->0x00
//  Read path: reg_rdata is a registered mux of reg_addr. It is valid 1 clk after any change of
//   reg_addr or the addressed content, and is driven continuously, not gated by reg_rd.
//   FIFO_DATA reads 0x00 when empty.
//  Read strobe: rd_evt = reg_rd & ~reg_rd_q (rising edge only), so a multi-cycle reg_rd level counts as one read.
//   Side effects use the reg_addr of the rd_evt cycle. Only FIFO_DATA has a read side effect.
//  Pop: rd_evt at 0x07 with FIFO non-empty advances the head. reg_rdata shows the new head next clk.
//   A pop while empty is ignored and has no flag.
//  Push: fifo_wr_i while not full stores the data. A push while full drops the data and sets IRQ_STAT[7].
//  Push and pop in the same clk:
//   - FIFO full: both occur, count unchanged.
//   - FIFO empty: push only.
//  fifo_full_o is registered and matches count==FIFO_DEPTH in the same cycle the count updates.
//  IRQ_STAT next = (stat & ~(wr@0x04 ? wdata : 0)) | {ovf_evt, evt_i}. Set wins over a simultaneous W1C clear.
//  irq_o is updated 1 clk after IRQ_STAT/IRQ_MASK change.
//  Writes take effect on the clk after reg_wr. A write and rd_evt in the same clk are both honoured.
//  A read of a RW register returns its value after the write completes.
//  Mid-operation reset wins over everything and empties the FIFO; pending strobes are lost.
// TESTING
//  1 Reset, read 0x00/0x01/0x09/0xFF -> 0xA5, 0x12, 0x00, 0x00; ctrl_o=0, irq_o=0.
//  2 Write 0x3C to 0x02, 0x81 to 0x03 -> readback 0x3C/0x81; ctrl_o=0x81; WR_COUNT=0x02.
//  3 Push 0x11,0x22,0x33; hold reg_rd high 50 clk at 0x07 -> rdata=0x11, one pop only;
//    then two pulses -> 0x22, 0x33; FIFO_STAT=0x40.
//  4 Push 9 bytes into depth 8 -> fifo_full_o=1, FIFO_STAT=0x88, IRQ_STAT[7]=1; with MASK=0x80, irq_o=1 next clk.
//  5 evt_i[0] pulse in the same clk as a W1C write 0x01 to 0x04 -> IRQ_STAT[0] stays 1;
//    a second W1C -> 0, irq_o drops.
//  6 FIFO full, push 0xEE and pop in the same clk -> count stays 8, no overflow, 0xEE is the tail;
//    rst during traffic -> FIFO_STAT=0x40.

Source files
------------

// File: rtl/i2c_reg_bank.sv
// Register bank behind the I2C slave strobe interface: ID/version, scratch, control,
// W1C interrupt block, write counter and an FPGA->MCU mailbox FIFO drained by pop-on-read.
module i2c_reg_bank #(
  parameter logic [7:0] DEVICE_ID  = 8'hA5,
  parameter logic [7:0] VERSION    = 8'h12,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       reg_wr,
  output logic [7:0] reg_rdata,
  input  logic       reg_rd,
  input  logic [6:0] evt_i,
  input  logic       fifo_wr_i,
  input  logic [7:0] fifo_wdata_i,
  output logic       fifo_full_o,
  output logic [7:0] ctrl_o,
  output logic       irq_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [7:0] ADDR_DEVICE_ID = 8'h00;
  localparam logic [7:0] ADDR_VERSION   = 8'h01;
  localparam logic [7:0] ADDR_SCRATCH   = 8'h02;
  localparam logic [7:0] ADDR_CTRL      = 8'h03;
  localparam logic [7:0] ADDR_IRQ_STAT  = 8'h04;
  localparam logic [7:0] ADDR_IRQ_MASK  = 8'h05;
  localparam logic [7:0] ADDR_FIFO_STAT = 8'h06;
  localparam logic [7:0] ADDR_FIFO_DATA = 8'h07;
  localparam logic [7:0] ADDR_WR_COUNT  = 8'h08;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // State
  logic [7:0]       scratch_q,  scratch_d;
  logic [7:0]       ctrl_q,     ctrl_d;
  logic [7:0]       irq_stat_q, irq_stat_d;
  logic [7:0]       irq_mask_q, irq_mask_d;
  logic [7:0]       wr_count_q, wr_count_d;
  logic             irq_q,      irq_d;
  logic [7:0]       rdata_q,    rdata_d;
  logic             reg_rd_q,   reg_rd_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic             full_q,     full_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  // Strobes and decoded events
  logic       rd_evt;
  logic       fifo_empty;
  logic       do_pop;
  logic       do_push;
  logic       ovf_evt;
  logic [7:0] w1c_mask;
  logic [7:0] fifo_head;
  logic [7:0] fifo_stat;

  // A held reg_rd level must count as one read, so only its rising edge acts.
  assign rd_evt     = reg_rd & ~reg_rd_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign fifo_stat  = {full_q, fifo_empty, 1'b0, 5'(count_q)};

  // When full, a pop in the same cycle frees the slot the push lands in.
  always_comb begin
    do_pop  = rd_evt && (reg_addr == ADDR_FIFO_DATA) && !fifo_empty;
    do_push = fifo_wr_i && (!full_q || do_pop);
    ovf_evt = fifo_wr_i && full_q && !do_pop;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_FULL);
  end

  always_comb begin
    scratch_d  = scratch_q;
    ctrl_d     = ctrl_q;
    irq_mask_d = irq_mask_q;
    wr_count_d = wr_count_q;
    w1c_mask   = 8'h00;
    if (reg_wr) begin
      wr_count_d = wr_count_q + 8'd1;
      case (reg_addr)
        ADDR_SCRATCH:  scratch_d  = reg_wdata;
        ADDR_CTRL:     ctrl_d     = reg_wdata;
        ADDR_IRQ_MASK: irq_mask_d = reg_wdata;
        ADDR_IRQ_STAT: w1c_mask   = reg_wdata;
        default:       ;
      endcase
    end
    // New events are ORed in after the clear, so a set beats a simultaneous W1C.
    irq_stat_d = (irq_stat_q & ~w1c_mask) | {ovf_evt, evt_i};
    irq_d      = |(irq_stat_q & irq_mask_q);
    reg_rd_d   = reg_rd;
  end

  // Read data is a registered mux of the live address, independent of reg_rd.
  always_comb begin
    rdata_d = 8'h00;
    case (reg_addr)
      ADDR_DEVICE_ID: rdata_d = DEVICE_ID;
      ADDR_VERSION:   rdata_d = VERSION;
      ADDR_SCRATCH:   rdata_d = scratch_q;
      ADDR_CTRL:      rdata_d = ctrl_q;
      ADDR_IRQ_STAT:  rdata_d = irq_stat_q;
      ADDR_IRQ_MASK:  rdata_d = irq_mask_q;
      ADDR_FIFO_STAT: rdata_d = fifo_stat;
      ADDR_FIFO_DATA: rdata_d = fifo_head;
      ADDR_WR_COUNT:  rdata_d = wr_count_q;
      default:        rdata_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      scratch_q  <= 8'h00;
      ctrl_q     <= 8'h00;
      irq_stat_q <= 8'h00;
      irq_mask_q <= 8'h00;
      wr_count_q <= 8'h00;
      irq_q      <= 1'b0;
      rdata_q    <= 8'h00;
      reg_rd_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
    end else begin
      scratch_q  <= scratch_d;
      ctrl_q     <= ctrl_d;
      irq_stat_q <= irq_stat_d;
      irq_mask_q <= irq_mask_d;
      wr_count_q <= wr_count_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      reg_rd_q   <= reg_rd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
    end
  end

  // NOTE: the storage array is not reset; the empty flag masks stale entries, keeping it plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= fifo_wdata_i;
  end

  assign reg_rdata   = rdata_q;
  assign fifo_full_o = full_q;
  assign ctrl_o      = ctrl_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Self-checking bench for i2c_reg_bank: expected values queued when stimulus is driven,
// popped and compared when the DUT output is sampled (1 ns after the rising edge).
module tb_i2c_reg_bank;

  logic       clk;
  logic       rst;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic [7:0] reg_rdata;
  logic       reg_rd;
  logic [6:0] evt_i;
  logic       fifo_wr_i;
  logic [7:0] fifo_wdata_i;
  logic       fifo_full_o;
  logic [7:0] ctrl_o;
  logic       irq_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];   // expected observations, pushed at stimulus time
  logic [7:0] mbox_q[$];  // mailbox model
  logic [7:0] got;
  logic [7:0] exp;

  i2c_reg_bank #(.DEVICE_ID(8'hA5), .VERSION(8'h12), .FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_wr       (reg_wr),
    .reg_rdata    (reg_rdata),
    .reg_rd       (reg_rd),
    .evt_i        (evt_i),
    .fifo_wr_i    (fifo_wr_i),
    .fifo_wdata_i (fifo_wdata_i),
    .fifo_full_o  (fifo_full_o),
    .ctrl_o       (ctrl_o),
    .irq_o        (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
    reg_addr = a;
    tick();
    d = reg_rdata;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_wr    = 1'b1;
    tick();
    reg_wr    = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    fifo_wr_i    = 1'b1;
    fifo_wdata_i = d;
    if (mbox_q.size() < 8) mbox_q.push_back(d);
    tick();
    fifo_wr_i    = 1'b0;
  endtask

  task automatic pop_pulse();
    reg_addr = 8'h07;
    reg_rd   = 1'b1;
    tick();
    reg_rd   = 1'b0;
    tick();
  endtask

  function automatic logic [7:0] fifo_stat_model();
    int n;
    n = mbox_q.size();
    return {(n == 8), (n == 0), 1'b0, 5'(n)};
  endfunction

  task automatic test_reset();
    logic [7:0] addrs [5];
    addrs = '{8'h00, 8'h01, 8'h09, 8'hFF, 8'h06};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mbox_q.delete();
    tests_run++;
    if (reg_rdata !== 8'h00 || ctrl_o !== 8'h00 || irq_o !== 1'b0 || fifo_full_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rdata=%02h ctrl=%02h irq=%b full=%b, required 00 00 0 0",
               reg_rdata, ctrl_o, irq_o, fifo_full_o);
    end
    exp_q.push_back(8'hA5); exp_q.push_back(8'h12); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(fifo_stat_model());
    foreach (addrs[i]) begin
      read_reg(addrs[i], got);
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL reset_read@%02h: got %02h required %02h", addrs[i], got, exp);
      end
    end
  endtask

  task automatic test_rw_regs();
    write_reg(8'h02, 8'h3C);
    write_reg(8'h03, 8'h81);
    exp_q.push_back(8'h3C); exp_q.push_back(8'h81); exp_q.push_back(8'h02);
    read_reg(8'h02, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL scratch: got %02h required %02h", got, exp); end
    read_reg(8'h03, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL ctrl_read: got %02h required %02h", got, exp); end
    tests_run++;
    if (ctrl_o !== 8'h81) begin tests_failed++; $display("FAIL ctrl_o: got %02h required 81", ctrl_o); end
    read_reg(8'h08, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL wr_count: got %02h required %02h", got, exp); end
  endtask

  task automatic test_fifo_pop_level();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    // Value on the bus at the read edge is the popped byte
    read_reg(8'h07, got); exp = mbox_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL level_read: got %02h required %02h", got, exp); end
    reg_rd = 1'b1;
    repeat (50) tick();
    reg_rd = 1'b0;
    tick();
    exp_q.push_back(fifo_stat_model());
    read_reg(8'h06, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL level_one_pop: stat %02h required %02h", got, exp); end
    for (int k = 0; k < 2; k++) begin
      read_reg(8'h07, got); exp = mbox_q.pop_front(); tests_run++;
      if (got !== exp) begin tests_failed++; $display("FAIL pulse_read%0d: got %02h required %02h", k, got, exp); end
      pop_pulse();
    end
    pop_pulse();  // pop while empty: ignored
    exp_q.push_back(8'h40); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    read_reg(8'h06, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL empty_stat: got %02h required %02h", got, exp); end
    read_reg(8'h07, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL empty_data: got %02h required %02h", got, exp); end
    read_reg(8'h04, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL empty_pop_flag: got %02h required %02h", got, exp); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 9; k++) push_byte(8'h50 + 8'(k));
    tests_run++;
    if (fifo_full_o !== 1'b1) begin tests_failed++; $display("FAIL full_o: got %b required 1", fifo_full_o); end
    exp_q.push_back(fifo_stat_model()); exp_q.push_back(8'h80);
    read_reg(8'h06, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp || got !== 8'h88) begin tests_failed++; $display("FAIL full_stat: got %02h required %02h", got, exp); end
    read_reg(8'h04, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL ovf_flag: got %02h required %02h", got, exp); end
    write_reg(8'h05, 8'h80);
    tests_run++;
    if (irq_o !== 1'b0) begin tests_failed++; $display("FAIL irq_latency: got %b required 0", irq_o); end
    tick();
    tests_run++;
    if (irq_o !== 1'b1) begin tests_failed++; $display("FAIL irq_set: got %b required 1", irq_o); end
  endtask

  task automatic test_w1c_race();
    write_reg(8'h04, 8'hFF);
    write_reg(8'h05, 8'h01);
    reg_addr  = 8'h04;
    reg_wdata = 8'h01;
    reg_wr    = 1'b1;
    evt_i     = 7'h01;
    tick();
    reg_wr    = 1'b0;
    evt_i     = 7'h00;
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    read_reg(8'h04, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL set_wins: got %02h required %02h", got, exp); end
    tick();
    tests_run++;
    if (irq_o !== 1'b1) begin tests_failed++; $display("FAIL irq_evt: got %b required 1", irq_o); end
    write_reg(8'h04, 8'h01);
    read_reg(8'h04, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL w1c_clear: got %02h required %02h", got, exp); end
    tests_run++;
    if (irq_o !== 1'b0) begin tests_failed++; $display("FAIL irq_drop: got %b required 0", irq_o); end
  endtask

  task automatic test_back_to_back();
    read_reg(8'h07, got);
    reg_rd       = 1'b1;
    fifo_wr_i    = 1'b1;
    fifo_wdata_i = 8'hEE;
    tick();
    reg_rd       = 1'b0;
    fifo_wr_i    = 1'b0;
    void'(mbox_q.pop_front());
    mbox_q.push_back(8'hEE);
    exp_q.push_back(fifo_stat_model()); exp_q.push_back(8'h00);
    read_reg(8'h06, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL full_pushpop_stat: got %02h required %02h", got, exp); end
    read_reg(8'h04, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL full_pushpop_ovf: got %02h required %02h", got, exp); end
    for (int k = 0; k < 8; k++) begin
      read_reg(8'h07, got); exp = mbox_q.pop_front(); tests_run++;
      if (got !== exp) begin tests_failed++; $display("FAIL drain%0d: got %02h required %02h", k, got, exp); end
      pop_pulse();
    end
    push_byte(8'hA1);
    fifo_wr_i    = 1'b1;
    fifo_wdata_i = 8'hA2;
    rst          = 1'b1;
    tick();
    rst          = 1'b0;
    fifo_wr_i    = 1'b0;
    mbox_q.delete();
    tests_run++;
    if (reg_rdata !== 8'h00 || ctrl_o !== 8'h00 || fifo_full_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: rdata=%02h ctrl=%02h full=%b required 00 00 0", reg_rdata, ctrl_o, fifo_full_o);
    end
    exp_q.push_back(fifo_stat_model()); exp_q.push_back(8'h00);
    read_reg(8'h06, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp || got !== 8'h40) begin tests_failed++; $display("FAIL midrst_stat: got %02h required %02h", got, exp); end
    read_reg(8'h08, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL midrst_wrcount: got %02h required %02h", got, exp); end
  endtask

  task automatic test_wr_count_wrap();
    for (int k = 0; k < 255; k++) write_reg(8'h09, 8'(k));
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    read_reg(8'h08, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL wrcount_ff: got %02h required %02h", got, exp); end
    write_reg(8'h0A, 8'h00);
    read_reg(8'h08, got); exp = exp_q.pop_front(); tests_run++;
    if (got !== exp) begin tests_failed++; $display("FAIL wrcount_wrap: got %02h required %02h", got, exp); end
  endtask

  initial begin
    rst          = 1'b1;
    reg_addr     = 8'h00;
    reg_wdata    = 8'h00;
    reg_wr       = 1'b0;
    reg_rd       = 1'b0;
    evt_i        = 7'h00;
    fifo_wr_i    = 1'b0;
    fifo_wdata_i = 8'h00;
    tick();
    test_reset();
    test_rw_regs();
    test_fifo_pop_level();
    test_overflow();
    test_w1c_race();
    test_back_to_back();
    test_wr_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
